// File: rtl/irq_req_latch.sv
// Request capture for the 4:2 priority encoder: sticky pending bits,
// masked encoder drive and a valid/ready interrupt-ID presenter.
module irq_req_latch #(
  parameter int EDGE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_in,
  input  logic [3:0] mask,
  output logic [3:0] pend,
  input  logic [1:0] enc_y,
  output logic       irq_valid,
  output logic [1:0] irq_id,
  input  logic       irq_ready,
  output logic [3:0] overflow,
  input  logic       clr_ovf
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [3:0] req_q;
  logic [3:0] pend_r;
  logic [3:0] evt;
  logic [3:0] clr;
  logic [3:0] ovf_set;
  logic       any;
  logic       accept;

  // req_q resets low so a line held across reset release is one event
  assign evt = (EDGE != 0) ? (req_in & ~req_q) : req_in;

  assign pend    = pend_r & mask;
  assign any     = |pend;
  assign accept  = (state == PRESENT) && irq_ready;
  assign ovf_set = evt & pend_r & ~clr;

  always_comb begin
    clr = '0;
    if (accept) clr[irq_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q    <= '0;
      pend_r   <= '0;
      overflow <= '0;
    end else begin
      req_q    <= req_in;
      pend_r   <= evt | (pend_r & ~clr);
      overflow <= ovf_set | (overflow & ~{4{clr_ovf}});
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (any) state_n = LOAD;
      LOAD:    state_n = any ? PRESENT : IDLE;
      PRESENT: if (irq_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // enc_y is only trusted while the masked pending vector is non-zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_id <= '0;
    end else if (state == LOAD && any) begin
      irq_id <= enc_y;
    end
  end

  always_comb begin
    irq_valid = (state == PRESENT);
  end

endmodule

// File: tb/tb_irq_req_latch.sv
// Directed bench for irq_req_latch with a behavioural 4:2 priority
// encoder closing the pend -> enc_y loop.
module tb_irq_req_latch;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_in;
  logic [3:0] mask;
  logic [3:0] pend;
  logic [1:0] enc_y;
  logic       irq_valid;
  logic [1:0] irq_id;
  logic       irq_ready;
  logic [3:0] overflow;
  logic       clr_ovf;

  int checks;
  int errors;

  irq_req_latch #(.EDGE(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .mask      (mask),
    .pend      (pend),
    .enc_y     (enc_y),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .irq_ready (irq_ready),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always_comb begin
    enc_y = 2'b00;
    if (pend[3]) enc_y = 2'b11;
    else if (pend[2]) enc_y = 2'b10;
    else if (pend[1]) enc_y = 2'b01;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int ids[4];
    int n;
    rst_n = 1'b0;
    req_in = 4'b1111;
    mask = 4'hF;
    irq_ready = 1'b0;
    clr_ovf = 1'b0;
    repeat (3) tick();
    checks++;
    if (pend !== 4'b0000) begin
      errors++;
      $display("FAIL rst_pend got %b want 0000", pend);
    end
    checks++;
    if (irq_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %b want 0", irq_valid);
    end
    checks++;
    if (overflow !== 4'b0000) begin
      errors++;
      $display("FAIL rst_ovf got %b want 0000", overflow);
    end
    checks++;
    if (irq_id !== 2'b00) begin
      errors++;
      $display("FAIL rst_id got %b want 00", irq_id);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (pend !== 4'b1111) begin
      errors++;
      $display("FAIL rst_release_pend got %b want 1111", pend);
    end
    req_in = 4'b0000;
    irq_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (irq_valid === 1'b1 && n < 4) begin
        ids[n] = int'(irq_id);
        n++;
      end
      if (pend === 4'b0000 && irq_valid === 1'b0) break;
    end
    checks++;
    if (n != 4 || pend !== 4'b0000) begin
      errors++;
      $display("FAIL drain_count got %0d pend %b want 4 pend 0000", n, pend);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < n) begin
        checks++;
        if (ids[i] != 3 - i) begin
          errors++;
          $display("FAIL drain_order[%0d] got %0d want %0d", i, ids[i], 3 - i);
        end
      end
    end
  endtask

  task automatic test_single();
    mask = 4'hF;
    irq_ready = 1'b1;
    req_in = 4'b0010;
    tick();
    req_in = 4'b0000;
    checks++;
    if (pend !== 4'b0010 || irq_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_k got pend %b valid %b want 0010 0", pend, irq_valid);
    end
    tick();
    checks++;
    if (irq_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_k1 got valid %b want 0", irq_valid);
    end
    tick();
    checks++;
    if (irq_valid !== 1'b1 || irq_id !== 2'b01) begin
      errors++;
      $display("FAIL single_k2 got valid %b id %b want 1 01", irq_valid, irq_id);
    end
    tick();
    checks++;
    if (irq_valid !== 1'b0 || pend !== 4'b0000) begin
      errors++;
      $display("FAIL single_acc got valid %b pend %b want 0 0000", irq_valid, pend);
    end
  endtask

  task automatic test_priority();
    irq_ready = 1'b1;
    req_in = 4'b0101;
    tick();
    req_in = 4'b0000;
    tick();
    tick();
    checks++;
    if (irq_valid !== 1'b1 || irq_id !== 2'b10) begin
      errors++;
      $display("FAIL prio_first got valid %b id %b want 1 10", irq_valid, irq_id);
    end
    tick();
    checks++;
    if (irq_valid !== 1'b0 || pend !== 4'b0001) begin
      errors++;
      $display("FAIL prio_clr got valid %b pend %b want 0 0001", irq_valid, pend);
    end
    tick();
    tick();
    checks++;
    if (irq_valid !== 1'b1 || irq_id !== 2'b00) begin
      errors++;
      $display("FAIL prio_second got valid %b id %b want 1 00", irq_valid, irq_id);
    end
    tick();
    checks++;
    if (irq_valid !== 1'b0 || pend !== 4'b0000) begin
      errors++;
      $display("FAIL prio_done got valid %b pend %b want 0 0000", irq_valid, pend);
    end
  endtask

  task automatic test_overflow();
    int seen;
    irq_ready = 1'b0;
    req_in = 4'b1000;
    tick();
    req_in = 4'b0000;
    tick();
    req_in = 4'b1000;
    tick();
    req_in = 4'b0000;
    checks++;
    if (irq_valid !== 1'b1 || irq_id !== 2'b11 || overflow !== 4'b1000) begin
      errors++;
      $display("FAIL ovf_set got valid %b id %b ovf %b want 1 11 1000",
               irq_valid, irq_id, overflow);
    end
    irq_ready = 1'b1;
    tick();
    seen = 0;
    repeat (4) begin
      tick();
      if (irq_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || pend !== 4'b0000 || overflow !== 4'b1000) begin
      errors++;
      $display("FAIL ovf_one_grant got extra %0d pend %b ovf %b want 0 0000 1000",
               seen, pend, overflow);
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    checks++;
    if (overflow !== 4'b0000) begin
      errors++;
      $display("FAIL ovf_clr got %b want 0000", overflow);
    end
  endtask

  task automatic test_mask();
    int seen;
    irq_ready = 1'b1;
    mask = 4'b1011;
    req_in = 4'b0100;
    tick();
    req_in = 4'b0000;
    checks++;
    if (pend !== 4'b0000) begin
      errors++;
      $display("FAIL mask_pend got %b want 0000", pend);
    end
    seen = 0;
    repeat (10) begin
      tick();
      if (irq_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL mask_hold got %0d valid cycles want 0", seen);
    end
    mask = 4'hF;
    tick();
    tick();
    checks++;
    if (irq_valid !== 1'b1 || irq_id !== 2'b10 || pend !== 4'b0100) begin
      errors++;
      $display("FAIL mask_open got valid %b id %b pend %b want 1 10 0100",
               irq_valid, irq_id, pend);
    end
    tick();
    checks++;
    if (irq_valid !== 1'b0 || pend !== 4'b0000) begin
      errors++;
      $display("FAIL mask_acc got valid %b pend %b want 0 0000", irq_valid, pend);
    end
  endtask

  task automatic test_collision();
    irq_ready = 1'b0;
    req_in = 4'b1000;
    tick();
    req_in = 4'b0000;
    tick();
    tick();
    checks++;
    if (irq_valid !== 1'b1 || irq_id !== 2'b11) begin
      errors++;
      $display("FAIL coll_first got valid %b id %b want 1 11", irq_valid, irq_id);
    end
    irq_ready = 1'b1;
    req_in = 4'b1000;
    tick();
    req_in = 4'b0000;
    checks++;
    if (pend !== 4'b1000 || irq_valid !== 1'b0 || overflow !== 4'b0000) begin
      errors++;
      $display("FAIL coll_acc got pend %b valid %b ovf %b want 1000 0 0000",
               pend, irq_valid, overflow);
    end
    tick();
    tick();
    checks++;
    if (irq_valid !== 1'b1 || irq_id !== 2'b11) begin
      errors++;
      $display("FAIL coll_second got valid %b id %b want 1 11", irq_valid, irq_id);
    end
    tick();
    checks++;
    if (pend !== 4'b0000 || overflow !== 4'b0000) begin
      errors++;
      $display("FAIL coll_done got pend %b ovf %b want 0000 0000", pend, overflow);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    irq_ready = 1'b0;
    req_in = 4'b0010;
    tick();
    req_in = 4'b0000;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (irq_valid !== 1'b0 || pend !== 4'b0000) begin
      errors++;
      $display("FAIL midrst got valid %b pend %b want 0 0000", irq_valid, pend);
    end
    rst_n = 1'b1;
    irq_ready = 1'b1;
    seen = 0;
    repeat (5) begin
      tick();
      if (irq_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrst_after got %0d valid cycles want 0", seen);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_priority();
    test_overflow();
    test_mask();
    test_collision();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
